// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar serial link.
// The transmitter and this receiver both use the record character
// constants. This package also holds the receiver and parser state
// encodings and a digit-classification helper.
package sonar_pkg;

    localparam logic [6:0] CHAR_SEP  = 7'h2C;  // ','
    localparam logic [6:0] CHAR_FIM  = 7'h23;  // '#'
    localparam logic [6:0] CHAR_ZERO = 7'h30;  // '0'
    localparam logic [6:0] CHAR_NOVE = 7'h39;  // '9'

    // The parser state code is exported on db_estado, so the values are pinned here.
    typedef enum logic [3:0] {
        A2     = 4'd0,
        A1     = 4'd1,
        A0     = 4'd2,
        SEP    = 4'd3,
        D2     = 4'd4,
        D1     = 4'd5,
        D0     = 4'd6,
        TERM   = 4'd7,
        RESYNC = 4'd8
    } estado_parser_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DADOS    = 3'd2,
        PARIDADE = 3'd3,
        STOP     = 3'd4
    } estado_rx_t;

    function automatic logic ehDigito(input logic [6:0] c);
        return (c >= CHAR_ZERO) && (c <= CHAR_NOVE);
    endfunction

endpackage

// File: rtl/sonar_rx_registro_if.sv
// Bundle of the serial line and the decoded record outputs.
//   rxd           serial line into the receiver (idle high)
//   angulo        BCD angle of the last valid record
//   distancia     BCD distance of the last valid record
//   pronto        one-cycle strobe when angulo/distancia update
//   erro_paridade one-cycle strobe on a parity error
//   erro_formato  one-cycle strobe on a stop-bit or character error
//   db_estado     parser state code
// The slave modport is the receiver side; the master modport is the line driver/observer side.
interface sonar_rx_registro_if;

    logic        rxd;
    logic [11:0] angulo;
    logic [11:0] distancia;
    logic        pronto;
    logic        erro_paridade;
    logic        erro_formato;
    logic [3:0]  db_estado;

    modport master (
        output rxd,
        input  angulo, distancia, pronto, erro_paridade, erro_formato, db_estado
    );

    modport slave (
        input  rxd,
        output angulo, distancia, pronto, erro_paridade, erro_formato, db_estado
    );

endinterface

// File: rtl/sonar_rx_registro_rx.sv
// 7O1 character receiver: 2-flop synchronizer, bit timing and frame FSM.
// It also checks odd parity and the stop bit.
//   clock, reset  system clock, asynchronous active-high reset
//   rxd           raw serial line (asynchronous, idle high)
//   dados         received 7-bit character
//   valido        one-cycle strobe, the cycle after the stop-bit sample
//   ok_par        odd parity held for this character
//   ok_stop       stop bit was high
module rx_serial_7O1
    import sonar_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int N_BAUD       = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    output logic [6:0] dados,
    output logic       valido,
    output logic       ok_par,
    output logic       ok_stop
);

    localparam logic [N_BAUD-1:0] CNT_MEIO = N_BAUD'(CLKS_PER_BIT / 2 - 1);
    localparam logic [N_BAUD-1:0] CNT_BIT  = N_BAUD'(CLKS_PER_BIT - 1);

    logic             sync1_q, sync2_q, prev_q;
    estado_rx_t       estado_q, estado_d;
    logic [N_BAUD-1:0] cnt_q, cnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [6:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [6:0]       dados_q, dados_d;
    logic             valido_q, valido_d;
    logic             okPar_q, okPar_d;
    logic             okStop_q, okStop_d;
    logic             fimBit;

    // Synchronizer and previous-sample flop reset high, so reset looks like an idle line
    // and cannot fake a start edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= IDLE;
            cnt_q    <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            dados_q  <= '0;
            valido_q <= 1'b0;
            okPar_q  <= 1'b0;
            okStop_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            dados_q  <= dados_d;
            valido_q <= valido_d;
            okPar_q  <= okPar_d;
            okStop_q <= okStop_d;
        end
    end

    // Detect the start edge, then sample at half a bit.
    // After that, sample one full bit period apart.
    // The stop sample returns straight to IDLE, so a start bit right behind
    // a single stop bit is still caught.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        dados_d  = dados_q;
        okPar_d  = okPar_q;
        okStop_d = okStop_q;
        valido_d = 1'b0;
        fimBit   = (cnt_q == CNT_BIT);

        case (estado_q)
            IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) begin
                    estado_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_MEIO) begin
                    cnt_d    = '0;
                    bitIdx_d = '0;
                    estado_d = sync2_q ? IDLE : DADOS;
                end else begin
                    cnt_d = cnt_q + N_BAUD'(1);
                end
            end
            DADOS: begin
                if (fimBit) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[6:1]};
                    if (bitIdx_q == 3'd6) begin
                        estado_d = PARIDADE;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + N_BAUD'(1);
                end
            end
            PARIDADE: begin
                if (fimBit) begin
                    cnt_d    = '0;
                    par_d    = sync2_q;
                    estado_d = STOP;
                end else begin
                    cnt_d = cnt_q + N_BAUD'(1);
                end
            end
            STOP: begin
                if (fimBit) begin
                    cnt_d    = '0;
                    dados_d  = shift_q;
                    okPar_d  = ^{shift_q, par_q};
                    okStop_d = sync2_q;
                    valido_d = 1'b1;
                    estado_d = IDLE;
                end else begin
                    cnt_d = cnt_q + N_BAUD'(1);
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    assign dados   = dados_q;
    assign valido  = valido_q;
    assign ok_par  = okPar_q;
    assign ok_stop = okStop_q;

endmodule

// File: rtl/sonar_rx_registro.sv
// Sonar record receiver: parses "AAA,DDD#" records from the 7O1 stream.
// Each complete, error-free record is presented as two 12-bit BCD words.
//   clock, reset  system clock, asynchronous active-high reset
//   bus           slave side of sonar_rx_registro_if (rxd in, record/status out)
module sonar_rx_registro
    import sonar_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int N_BAUD       = 9
) (
    input  logic                 clock,
    input  logic                 reset,
    sonar_rx_registro_if.slave   bus
);

    logic [6:0] dados;
    logic       valido, okPar, okStop;

    rx_serial_7O1 #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .N_BAUD       (N_BAUD)
    ) u_rx (
        .clock   (clock),
        .reset   (reset),
        .rxd     (bus.rxd),
        .dados   (dados),
        .valido  (valido),
        .ok_par  (okPar),
        .ok_stop (okStop)
    );

    estado_parser_t estado_q, estado_d;
    logic [11:0]    sombraAng_q, sombraAng_d;
    logic [11:0]    sombraDist_q, sombraDist_d;
    logic [11:0]    angulo_q, angulo_d;
    logic [11:0]    distancia_q, distancia_d;
    logic           pronto_q, pronto_d;
    logic           erroPar_q, erroPar_d;
    logic           erroFmt_q, erroFmt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q     <= A2;
            sombraAng_q  <= '0;
            sombraDist_q <= '0;
            angulo_q     <= '0;
            distancia_q  <= '0;
            pronto_q     <= 1'b0;
            erroPar_q    <= 1'b0;
            erroFmt_q    <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            sombraAng_q  <= sombraAng_d;
            sombraDist_q <= sombraDist_d;
            angulo_q     <= angulo_d;
            distancia_q  <= distancia_d;
            pronto_q     <= pronto_d;
            erroPar_q    <= erroPar_d;
            erroFmt_q    <= erroFmt_d;
        end
    end

    // Digits go to shadow registers, so a damaged record never reaches the outputs.
    // Only a good '#' in TERM publishes them.
    // Any error goes to RESYNC, which waits silently for the next good '#'.
    always_comb begin
        estado_d     = estado_q;
        sombraAng_d  = sombraAng_q;
        sombraDist_d = sombraDist_q;
        angulo_d     = angulo_q;
        distancia_d  = distancia_q;
        pronto_d     = 1'b0;
        erroPar_d    = 1'b0;
        erroFmt_d    = 1'b0;

        if (valido) begin
            if (estado_q == RESYNC) begin
                if (okPar && okStop && dados == CHAR_FIM) begin
                    estado_d = A2;
                end
            end else if (!okPar || !okStop) begin
                erroPar_d = !okPar;
                erroFmt_d = !okStop;
                estado_d  = RESYNC;
            end else begin
                case (estado_q)
                    A2, A1, A0, D2, D1, D0: begin
                        if (ehDigito(dados)) begin
                            case (estado_q)
                                A2:      sombraAng_d[11:8]  = dados[3:0];
                                A1:      sombraAng_d[7:4]   = dados[3:0];
                                A0:      sombraAng_d[3:0]   = dados[3:0];
                                D2:      sombraDist_d[11:8] = dados[3:0];
                                D1:      sombraDist_d[7:4]  = dados[3:0];
                                default: sombraDist_d[3:0]  = dados[3:0];
                            endcase
                            estado_d = estado_parser_t'(estado_q + 4'd1);
                        end else begin
                            erroFmt_d = 1'b1;
                            estado_d  = RESYNC;
                        end
                    end
                    SEP: begin
                        if (dados == CHAR_SEP) begin
                            estado_d = D2;
                        end else begin
                            erroFmt_d = 1'b1;
                            estado_d  = RESYNC;
                        end
                    end
                    TERM: begin
                        if (dados == CHAR_FIM) begin
                            angulo_d    = sombraAng_q;
                            distancia_d = sombraDist_q;
                            pronto_d    = 1'b1;
                            estado_d    = A2;
                        end else begin
                            erroFmt_d = 1'b1;
                            estado_d  = RESYNC;
                        end
                    end
                    default: estado_d = RESYNC;
                endcase
            end
        end
    end

    assign bus.angulo        = angulo_q;
    assign bus.distancia     = distancia_q;
    assign bus.pronto        = pronto_q;
    assign bus.erro_paridade = erroPar_q;
    assign bus.erro_formato  = erroFmt_q;
    assign bus.db_estado     = estado_q;

endmodule

// File: tb/tb_sonar_rx_registro.sv
// Testbench for sonar_rx_registro with CLKS_PER_BIT = 8.
// A table of record strings with per-vector expectations drives the main checks.
// Hand-written sequences cover latency, the short glitch and reset mid-frame.
module tb_sonar_rx_registro;
    import sonar_pkg::*;

    localparam int CLKS = 8;

    typedef struct {
        string       texto;
        int          idxPar;
        int          idxStop;
        logic [11:0] expAng;
        logic [11:0] expDist;
        int          dPronto;
        int          dPar;
        int          dFmt;
        logic [3:0]  expEstado;
    } vetor_t;

    logic clock = 1'b0;
    logic reset;

    sonar_rx_registro_if bus();

    sonar_rx_registro #(
        .CLKS_PER_BIT (CLKS),
        .N_BAUD       (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int cycleCount = 0;
    int prontoCount = 0;
    int parCount = 0;
    int fmtCount = 0;
    int overlapCount = 0;
    int widthCount = 0;
    int hashStart = 0;
    int lastLatency = -1;
    int checks = 0;
    int errors = 0;
    logic prevPronto = 1'b0;
    logic prevPar = 1'b0;
    logic prevFmt = 1'b0;
    vetor_t vetores[$];

    always @(posedge clock) cycleCount <= cycleCount + 1;

    // Counts every output pulse. It also flags pulses wider than one cycle
    // and pronto coinciding with an error pulse.
    always @(negedge clock) begin
        if (bus.pronto) begin
            prontoCount++;
            lastLatency = cycleCount - hashStart;
        end
        if (bus.erro_paridade) parCount++;
        if (bus.erro_formato) fmtCount++;
        if (bus.pronto && (bus.erro_paridade || bus.erro_formato)) overlapCount++;
        if ((bus.pronto && prevPronto) || (bus.erro_paridade && prevPar) ||
            (bus.erro_formato && prevFmt)) widthCount++;
        prevPronto = bus.pronto;
        prevPar    = bus.erro_paridade;
        prevFmt    = bus.erro_formato;
    end

    task automatic checkOutput(input string nome, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nome, actual, expected);
        end
    endtask

    task automatic sendBit(input logic b);
        bus.rxd = b;
        repeat (CLKS) @(negedge clock);
    endtask

    task automatic sendChar(input logic [6:0] c, input bit flipPar, input bit badStop);
        logic p;
        p = ~^c;
        if (flipPar) p = ~p;
        if (c == CHAR_FIM) hashStart = cycleCount;
        sendBit(1'b0);
        for (int i = 0; i < 7; i++) sendBit(c[i]);
        sendBit(p);
        sendBit(!badStop);
        if (badStop) sendBit(1'b1);
    endtask

    task automatic sendString(input string s, input int idxPar, input int idxStop);
        logic [7:0] ch;
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            sendChar(ch[6:0], i == idxPar, i == idxStop);
        end
    endtask

    task automatic addVec(input string t, input int ip, input int is, input logic [11:0] a,
                          input logic [11:0] d, input int dp, input int dpar, input int dfmt,
                          input logic [3:0] est);
        vetor_t v;
        v.texto = t; v.idxPar = ip; v.idxStop = is; v.expAng = a; v.expDist = d;
        v.dPronto = dp; v.dPar = dpar; v.dFmt = dfmt; v.expEstado = est;
        vetores.push_back(v);
    endtask

    task automatic applyStimulus(input vetor_t v, input string tag);
        int p0, a0, f0;
        p0 = prontoCount; a0 = parCount; f0 = fmtCount;
        sendString(v.texto, v.idxPar, v.idxStop);
        repeat (20) @(negedge clock);
        checkOutput({tag, " angulo"}, int'(bus.angulo), int'(v.expAng));
        checkOutput({tag, " distancia"}, int'(bus.distancia), int'(v.expDist));
        checkOutput({tag, " pronto pulses"}, prontoCount - p0, v.dPronto);
        checkOutput({tag, " paridade pulses"}, parCount - a0, v.dPar);
        checkOutput({tag, " formato pulses"}, fmtCount - f0, v.dFmt);
        checkOutput({tag, " db_estado"}, int'(bus.db_estado), int'(v.expEstado));
    endtask

    initial begin
        int latency0;
        int p0, a0, f0;
        vetor_t vr;

        addVec("045,123#",         -1, -1, 12'h045, 12'h123, 1, 0, 0, 4'd0);
        addVec("180,007#000,999#", -1, -1, 12'h000, 12'h999, 2, 0, 0, 4'd0);
        addVec("090,050#",         -1, -1, 12'h090, 12'h050, 1, 0, 0, 4'd0);
        addVec("135,020#",          0, -1, 12'h090, 12'h050, 0, 1, 0, 4'd0);
        addVec("135,020#",         -1, -1, 12'h135, 12'h020, 1, 0, 0, 4'd0);
        addVec("04X,123#",         -1, -1, 12'h135, 12'h020, 0, 0, 1, 4'd0);
        addVec("010,200#",         -1, -1, 12'h010, 12'h200, 1, 0, 0, 4'd0);
        addVec("5",                -1,  0, 12'h010, 12'h200, 0, 0, 1, 4'd8);
        addVec("#",                -1, -1, 12'h010, 12'h200, 0, 0, 0, 4'd0);
        addVec("7",                 0,  0, 12'h010, 12'h200, 0, 1, 1, 4'd8);
        addVec("3#",               -1, -1, 12'h010, 12'h200, 0, 0, 0, 4'd0);
        addVec("123#",             -1, -1, 12'h010, 12'h200, 0, 0, 1, 4'd8);
        addVec("#",                -1, -1, 12'h010, 12'h200, 0, 0, 0, 4'd0);

        latency0 = -1;
        bus.rxd = 1'b1;
        reset = 1'b1;
        repeat (4) @(negedge clock);
        checkOutput("reset angulo", int'(bus.angulo), 0);
        checkOutput("reset distancia", int'(bus.distancia), 0);
        checkOutput("reset pulses", int'({bus.pronto, bus.erro_paridade, bus.erro_formato}), 0);
        checkOutput("reset db_estado", int'(bus.db_estado), int'(A2));
        reset = 1'b0;
        repeat (10) @(negedge clock);

        for (int i = 0; i < vetores.size(); i++) begin
            applyStimulus(vetores[i], $sformatf("vec%0d", i));
            if (i == 0) latency0 = lastLatency;
        end
        if (latency0 < 78 || latency0 > 82)
            checkOutput("latency in 78..82", latency0, 80);
        else
            checkOutput("latency in 78..82", 1, 1 + (latency0 - latency0));

        // Short low glitch on an idle line: no frame, no pulses
        p0 = prontoCount; a0 = parCount; f0 = fmtCount;
        bus.rxd = 1'b0;
        repeat (3) @(negedge clock);
        bus.rxd = 1'b1;
        repeat (150) @(negedge clock);
        checkOutput("glitch pulses", (prontoCount - p0) + (parCount - a0) + (fmtCount - f0), 0);
        checkOutput("glitch db_estado", int'(bus.db_estado), int'(A2));
        checkOutput("glitch angulo", int'(bus.angulo), 12'h010);

        // Reset in the middle of the 4th character of a record
        sendString("123", -1, -1);
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b0);
        checkOutput("pre-reset db_estado", int'(bus.db_estado), int'(SEP));
        reset = 1'b1;
        bus.rxd = 1'b1;
        @(negedge clock);
        checkOutput("mid reset angulo", int'(bus.angulo), 0);
        checkOutput("mid reset distancia", int'(bus.distancia), 0);
        checkOutput("mid reset db_estado", int'(bus.db_estado), int'(A2));
        checkOutput("mid reset pronto", int'(bus.pronto), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        vr.texto = "077,088#"; vr.idxPar = -1; vr.idxStop = -1;
        vr.expAng = 12'h077; vr.expDist = 12'h088; vr.dPronto = 1; vr.dPar = 0; vr.dFmt = 0;
        vr.expEstado = 4'd0;
        applyStimulus(vr, "after reset");

        checkOutput("pronto/error overlap", overlapCount, 0);
        checkOutput("pulse width violations", widthCount, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
